// File: rtl/alsu_arbiter_if.sv
// Requester, arbiter and ALSU handshake bundle for alsu_arbiter.
// The master side is the requesters plus the ALSU; the slave side is the arbiter.
interface alsu_arbiter_if;
  logic        req0;
  logic        req1;
  logic [15:0] cmd0;
  logic [15:0] cmd1;
  logic        gnt0;
  logic        gnt1;
  logic [15:0] alsu_cmd;
  logic [5:0]  alsu_out;
  logic [5:0]  result;
  logic        done;
  logic        err;
  logic        done_id;
  logic        busy;

  modport master (
    output req0, req1, cmd0, cmd1, alsu_out,
    input  gnt0, gnt1, alsu_cmd, result, done, err, done_id, busy
  );

  modport slave (
    input  req0, req1, cmd0, cmd1, alsu_out,
    output gnt0, gnt1, alsu_cmd, result, done, err, done_id, busy
  );
endinterface

// File: rtl/alsu_arbiter.sv
// Two-requester round-robin front end for an ALSU: validates and launches one
// command at a time, waits LATENCY cycles, then captures and reports the result.
module alsu_arbiter #(
  parameter int LATENCY = 2,
  parameter int STARTUP = 16
) (
  input logic           clk,
  input logic           rst,
  alsu_arbiter_if.slave bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  su_cnt;
  logic [3:0]  lat_cnt;
  logic        ptr;
  logic        gid;
  logic        startup_done;
  logic        gnt_any;
  logic        gnt_id;
  logic [15:0] gnt_cmd;
  logic        launch;
  logic        reject;
  logic        capture;

  logic [15:0] cmd_p1;
  logic [5:0]  res_p1;
  logic        vld_p1;
  logic        err_p1;
  logic        id_p1;

  // Reserved opcodes 110/111, and reduction flags on anything but AND/OR, are rejected.
  function automatic logic cmd_valid(input logic [15:0] c);
    logic [2:0] op;
    logic       red;
    op  = c[15:13];
    red = c[3] | c[2];
    return !(op[2] & op[1]) && !(red && (op[2:1] != 2'b00));
  endfunction

  assign startup_done = (su_cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt_any   = 1'b0;
    gnt_id    = 1'b0;
    gnt_cmd   = bus.cmd0;
    launch    = 1'b0;
    reject    = 1'b0;
    capture   = 1'b0;
    bus.busy  = 1'b1;
    case (state)
      IDLE: begin
        if (!rst && startup_done) begin
          bus.busy = 1'b0;
          if (bus.req0 || bus.req1) begin
            gnt_any = 1'b1;
            // Contested: the side that did not win last time goes first.
            gnt_id  = (bus.req0 && bus.req1) ? ~ptr : bus.req1;
            gnt_cmd = gnt_id ? bus.cmd1 : bus.cmd0;
            if (cmd_valid(gnt_cmd)) begin
              launch    = 1'b1;
              state_nxt = WAIT;
            end else begin
              reject = 1'b1;
            end
          end
        end
      end
      WAIT: begin
        if (lat_cnt == 4'd1) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    bus.gnt0 = gnt_any & ~gnt_id;
    bus.gnt1 = gnt_any & gnt_id;
  end

  // Stage p1: launch / capture registers, one cycle behind the grant or final WAIT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      su_cnt  <= 8'(STARTUP);
      ptr     <= 1'b1;
      lat_cnt <= 4'd0;
      gid     <= 1'b0;
      cmd_p1  <= '0;
      res_p1  <= '0;
      vld_p1  <= 1'b0;
      err_p1  <= 1'b0;
      id_p1   <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
      id_p1  <= 1'b0;
      if (!startup_done) su_cnt <= su_cnt - 8'd1;
      if (gnt_any) ptr <= gnt_id;
      if (launch) begin
        cmd_p1  <= gnt_cmd;
        gid     <= gnt_id;
        lat_cnt <= 4'(LATENCY);
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      if (reject) begin
        vld_p1 <= 1'b1;
        err_p1 <= 1'b1;
        id_p1  <= gnt_id;
      end
      if (capture) begin
        res_p1 <= bus.alsu_out;
        vld_p1 <= 1'b1;
        id_p1  <= gid;
      end
    end
  end

  assign bus.alsu_cmd = cmd_p1;
  assign bus.result   = res_p1;
  assign bus.done     = vld_p1;
  assign bus.err      = err_p1;
  assign bus.done_id  = id_p1;

endmodule

// File: tb/tb_alsu_arbiter.sv
// Bench for alsu_arbiter: vector table for arbitration/validation, hand sequences
// for startup, back-to-back, hold-off and reset abort; a scoreboard checks every done.
module tb_alsu_arbiter;
  localparam int LAT = 2;
  localparam int SU  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alsu_arbiter_if ifc();
  alsu_arbiter #(.LATENCY(LAT), .STARTUP(SU)) dut (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct {
    bit          id;
    bit          err;
    logic [5:0]  res;
    int          due;
  } exp_t;

  typedef struct {
    logic        req0;
    logic        req1;
    logic [15:0] cmd0;
    logic [15:0] cmd1;
    logic        g0;
    logic        g1;
    logic        rej;
  } vec_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_on = 1'b0;
  logic [5:0]  last_res = '0;

  function automatic logic [15:0] mk(input int op, input int a, input int b,
                                     input int cin, input int red_a);
    logic [2:0] o3, a3, b3;
    o3 = 3'(op); a3 = 3'(a); b3 = 3'(b);
    return {o3, a3, b3, 1'(cin), 1'b0, 1'b0, 1'(red_a), 1'b0, 2'b00};
  endfunction

  // Simple ALSU stand-in: opcode 010 adds A+B+cin, anything else concatenates A,B.
  function automatic logic [5:0] alsu_model(input logic [15:0] c);
    if (c[15:13] == 3'b010) return 6'(c[12:10]) + 6'(c[9:7]) + 6'(c[6]);
    return {c[12:10], c[9:7]};
  endfunction

  function automatic bit cmd_ok(input logic [15:0] c);
    logic [2:0] op;
    op = c[15:13];
    if (op == 3'd6 || op == 3'd7) return 1'b0;
    if ((c[3] || c[2]) && op > 3'd1) return 1'b0;
    return 1'b1;
  endfunction

  assign ifc.alsu_out = alsu_model(ifc.alsu_cmd);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (ifc.busy && n < 50) begin
      tick();
      n++;
    end
    if (ifc.busy) fail("wait_idle", "busy never dropped");
  endtask

  task automatic startup_probe(input string name);
    int k;
    bit busy_ok;
    bit found;
    k = 0; busy_ok = 1'b1; found = 1'b0;
    while (k < SU + 10 && !found) begin
      #1;
      if (ifc.gnt0) found = 1'b1;
      else begin
        if (!ifc.busy) busy_ok = 1'b0;
        tick();
        k++;
      end
    end
    check({name, "_grant_delay"}, k, SU);
    check({name, "_busy_held"}, {31'd0, busy_ok}, 1);
  endtask

  // Scoreboard: push on every observed grant, pop on every done.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] c;
    bit          v;
    if (mon_on) begin
      if (rst) begin
        sb.delete();
        last_res = '0;
      end
      check("err_without_done", {31'd0, ifc.err & ~ifc.done}, 0);
      check("id_without_done", {31'd0, ifc.done_id & ~ifc.done}, 0);
      check("single_grant", {31'd0, ifc.gnt0 & ifc.gnt1}, 0);
      if (ifc.done) begin
        if (sb.size() == 0) fail("unexpected_done", "done with nothing outstanding");
        else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.due);
          check("done_id", {31'd0, ifc.done_id}, {31'd0, e.id});
          check("done_err", {31'd0, ifc.err}, {31'd0, e.err});
          check("result", {26'd0, ifc.result}, {26'd0, (e.err ? last_res : e.res)});
          if (!e.err) last_res = e.res;
        end
      end else if (sb.size() != 0 && sb[0].due < cyc) begin
        void'(sb.pop_front());
        fail("done_missing", "expected done never arrived");
      end
      if (!rst && (ifc.gnt0 || ifc.gnt1)) begin
        e.id  = ifc.gnt1;
        c     = ifc.gnt1 ? ifc.cmd1 : ifc.cmd0;
        v     = cmd_ok(c);
        e.err = !v;
        e.res = alsu_model(c);
        e.due = cyc + (v ? LAT + 1 : 1);
        sb.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[8];
    logic [15:0] add_cmd;
    logic [15:0] last_cmd;
    logic [15:0] g_cmd;
    int          ng, first, last, lasti;
    bit          alt_ok, gap_ok;

    add_cmd = mk(2, 3, 5, 1, 0);
    vecs[0] = '{1'b1, 1'b1, mk(2, 1, 1, 0, 0), mk(3, 2, 6, 0, 0), 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, mk(4, 7, 1, 0, 0), mk(5, 1, 3, 0, 0), 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, mk(2, 7, 7, 1, 0), mk(5, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, mk(3, 3, 3, 0, 0), mk(1, 4, 4, 0, 1), 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, mk(2, 1, 1, 0, 0), mk(7, 1, 1, 0, 0), 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b0, mk(2, 1, 1, 0, 1), mk(2, 2, 2, 0, 0), 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, mk(0, 5, 2, 0, 1), mk(2, 2, 2, 0, 0), 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, mk(2, 2, 2, 0, 0), mk(6, 3, 3, 0, 0), 1'b0, 1'b1, 1'b1};

    rst = 1'b1;
    ifc.req0 = 1'b1; ifc.req1 = 1'b0;
    ifc.cmd0 = add_cmd; ifc.cmd1 = '0;
    tick();
    tick();
    mon_on = 1'b1;
    check("rst_alsu_cmd", {16'd0, ifc.alsu_cmd}, 0);
    check("rst_result", {26'd0, ifc.result}, 0);
    check("rst_done", {31'd0, ifc.done}, 0);
    check("rst_err", {31'd0, ifc.err}, 0);
    check("rst_done_id", {31'd0, ifc.done_id}, 0);
    #1;
    check("rst_gnt0", {31'd0, ifc.gnt0}, 0);
    check("rst_busy", {31'd0, ifc.busy}, 1);
    rst = 1'b0;

    // Startup window, then the add transaction
    startup_probe("startup");
    tick();
    check("add_alsu_cmd", {16'd0, ifc.alsu_cmd}, {16'd0, add_cmd});
    last_cmd = add_cmd;
    ifc.req0 = 1'b0;
    ifc.cmd0 = '1;
    tick();
    tick();
    check("add_done", {31'd0, ifc.done}, 1);
    check("add_done_id", {31'd0, ifc.done_id}, 0);
    check("add_result", {26'd0, ifc.result}, 9);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      wait_idle();
      ifc.req0 = vecs[i].req0; ifc.req1 = vecs[i].req1;
      ifc.cmd0 = vecs[i].cmd0; ifc.cmd1 = vecs[i].cmd1;
      #1;
      check($sformatf("vec%0d_gnt0", i), {31'd0, ifc.gnt0}, {31'd0, vecs[i].g0});
      check($sformatf("vec%0d_gnt1", i), {31'd0, ifc.gnt1}, {31'd0, vecs[i].g1});
      g_cmd = vecs[i].g1 ? vecs[i].cmd1 : vecs[i].cmd0;
      tick();
      if (vecs[i].rej) begin
        check($sformatf("vec%0d_rej_done", i), {31'd0, ifc.done}, 1);
        check($sformatf("vec%0d_rej_err", i), {31'd0, ifc.err}, 1);
        check($sformatf("vec%0d_rej_id", i), {31'd0, ifc.done_id}, {31'd0, vecs[i].g1});
        check($sformatf("vec%0d_cmd_held", i), {16'd0, ifc.alsu_cmd}, {16'd0, last_cmd});
      end else begin
        check($sformatf("vec%0d_alsu_cmd", i), {16'd0, ifc.alsu_cmd}, {16'd0, g_cmd});
        last_cmd = g_cmd;
      end
      ifc.req0 = 1'b0; ifc.req1 = 1'b0;
      ifc.cmd0 = '1; ifc.cmd1 = '1;
    end

    // Both requesters held continuously: alternate, regrant on each done cycle
    wait_idle();
    ifc.req0 = 1'b1; ifc.req1 = 1'b1;
    ifc.cmd0 = add_cmd; ifc.cmd1 = mk(3, 2, 1, 0, 0);
    ng = 0; first = -1; last = -1; lasti = 0; alt_ok = 1'b1; gap_ok = 1'b1;
    for (int i = 0; i < 14; i++) begin
      #1;
      if (ifc.gnt0 || ifc.gnt1) begin
        if (ng == 0) first = int'(ifc.gnt1);
        else begin
          if (int'(ifc.gnt1) == last) alt_ok = 1'b0;
          if (i - lasti != LAT + 1) gap_ok = 1'b0;
        end
        last = int'(ifc.gnt1); lasti = i; ng++;
      end
      tick();
    end
    ifc.req0 = 1'b0; ifc.req1 = 1'b0;
    check("rr_first", first, 0);
    check("rr_count", ng, 5);
    check("rr_alternate", {31'd0, alt_ok}, 1);
    check("rr_regrant_on_done", {31'd0, gap_ok}, 1);
    last_cmd = (last == 1) ? ifc.cmd1 : ifc.cmd0;

    // Back-to-back rejects on consecutive cycles
    wait_idle();
    ifc.req0 = 1'b1; ifc.req1 = 1'b1;
    ifc.cmd0 = mk(6, 1, 1, 0, 0); ifc.cmd1 = mk(7, 2, 2, 0, 0);
    ng = 0; first = -1; last = -1; alt_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (ifc.gnt0 || ifc.gnt1) begin
        if (ng == 0) first = int'(ifc.gnt1);
        else if (int'(ifc.gnt1) == last) alt_ok = 1'b0;
        last = int'(ifc.gnt1); ng++;
      end
      tick();
    end
    ifc.req0 = 1'b0; ifc.req1 = 1'b0;
    check("b2b_first", first, 1);
    check("b2b_count", ng, 4);
    check("b2b_alternate", {31'd0, alt_ok}, 1);
    check("b2b_cmd_held", {16'd0, ifc.alsu_cmd}, {16'd0, last_cmd});

    // Request arriving during WAIT is held off until the done cycle
    wait_idle();
    ifc.req0 = 1'b1; ifc.cmd0 = mk(2, 4, 1, 0, 0);
    #1;
    check("hold_gnt0", {31'd0, ifc.gnt0}, 1);
    tick();
    ifc.req0 = 1'b0; ifc.cmd0 = '1;
    ifc.req1 = 1'b1; ifc.cmd1 = mk(3, 1, 2, 0, 0);
    #1;
    check("hold_wait_gnt1", {31'd0, ifc.gnt1}, 0);
    check("hold_wait_busy", {31'd0, ifc.busy}, 1);
    tick();
    #1;
    check("hold_wait2_gnt1", {31'd0, ifc.gnt1}, 0);
    tick();
    #1;
    check("hold_done", {31'd0, ifc.done}, 1);
    check("hold_gnt1_on_done", {31'd0, ifc.gnt1}, 1);
    tick();
    ifc.req1 = 1'b0;

    // Reset one cycle into WAIT aborts the command without a done
    wait_idle();
    ifc.req0 = 1'b1; ifc.cmd0 = mk(2, 6, 6, 1, 0);
    #1;
    check("abort_gnt0", {31'd0, ifc.gnt0}, 1);
    tick();
    ifc.req0 = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_rst_gnt0", {31'd0, ifc.gnt0 | ifc.gnt1}, 0);
    check("abort_rst_busy", {31'd0, ifc.busy}, 1);
    tick();
    check("abort_alsu_cmd", {16'd0, ifc.alsu_cmd}, 0);
    check("abort_result", {26'd0, ifc.result}, 0);
    check("abort_done", {31'd0, ifc.done}, 0);
    check("abort_err", {31'd0, ifc.err}, 0);
    check("abort_done_id", {31'd0, ifc.done_id}, 0);
    rst = 1'b0;
    ifc.req0 = 1'b1; ifc.cmd0 = mk(2, 2, 2, 0, 0);
    startup_probe("restart");
    tick();
    ifc.req0 = 1'b0;
    wait_idle();
    for (int i = 0; i < 5; i++) tick();
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alsu_arbiter.md
ALSU_ARBITER -- requirements
Module: alsu_arbiter

Interface
REQ-001 Parameter LATENCY, default 2: clock cycles from command launch until alsu_out is valid; legal range 1..15.
REQ-002 Parameter STARTUP, default 16: cycles after reset release during which no grant is issued; covers the ALSU post-reset blink window; legal range 0..255.
REQ-003 clk  in  1  single clock; all logic on the rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 req0, req1  in  1 each  requester 0/1 command request; held high until granted.
REQ-006 cmd0, cmd1  in  16 each  requester command: [15:13] opcode, [12:10] A, [9:7] B, [6] cin, [5] serial_in, [4] direction, [3] red_op_A, [2] red_op_B, [1] bypass_A, [0] bypass_B.
REQ-007 gnt0, gnt1  out  1 each  accept strobe; combinational; one cycle.
REQ-008 alsu_cmd  out  16  command driven to the ALSU; same bit map as cmd0/cmd1.
REQ-009 alsu_out  in  6  ALSU result.
REQ-010 result  out  6  captured ALSU result.
REQ-011 done  out  1  one-cycle pulse: result valid, or command rejected.
REQ-012 err  out  1  one-cycle pulse coincident with done: command rejected.
REQ-013 done_id  out  1  requester index for the current done pulse.
REQ-014 busy  out  1  high when no grant can be issued this cycle.

Function
REQ-015 FSM states: IDLE, WAIT; startup counter runs alongside and gates grants.
REQ-016 Startup: counter loads STARTUP on reset and decrements to 0; while nonzero, gnt0 = gnt1 = 0 and busy = 1.
REQ-017 Grant: in IDLE with startup done and at least one req high, exactly one gnt is high that cycle; the granted cmd is latched at the closing edge.
REQ-018 Arbitration: round-robin over a last-granted pointer.
  - Only one request pending: that request wins.
  - Both pending: the requester not granted last wins.
  - Pointer resets to 1, so req0 wins the first contested grant.
REQ-019 Validity check, at grant: a command is invalid if opcode is 110 or 111, or if (red_op_A or red_op_B) = 1 with opcode not 000/001.
REQ-020 Invalid command:
  - No launch: alsu_cmd and result are unchanged.
  - done = err = 1 and done_id = grantee in the next cycle.
  - FSM stays in IDLE; the pointer still updates.
REQ-021 Valid command:
  - Latched cmd drives alsu_cmd from the cycle after grant; alsu_cmd holds until the next valid grant.
  - FSM enters WAIT with counter = LATENCY.
REQ-022 WAIT decrements once per cycle. When the counter reaches 1, the closing edge does all of the following:
  - result <= alsu_out.
  - done = 1 and done_id = grantee in the next cycle.
  - Return to IDLE.
REQ-023 Latency: grant in cycle N -> done and result valid in cycle N+LATENCY+1.
REQ-024 A new grant is allowed in the same cycle that done is high.
REQ-025 Back-to-back invalid grants are allowed on consecutive cycles.
REQ-026 In WAIT: gnt0 = gnt1 = 0 and busy = 1; requests are held and are not lost.
REQ-027 err is never high without done; done_id is 0 whenever done = 0.
REQ-028 Requester cmd inputs are sampled only on the grant cycle; later changes have no effect.

Reset
REQ-029 rst = 1 at a clock edge forces the following, regardless of state (including mid-WAIT):
  - State IDLE; startup counter = STARTUP; round-robin pointer = 1.
  - Registered outputs cleared: alsu_cmd, result, done, err, done_id.
  - gnt0 = gnt1 = 0 and busy = 1 while rst is high.
REQ-030 An in-flight command aborted by reset produces no done; requesters re-present after reset.

Verification
REQ-031 Startup: rst pulse, req0 high from the first cycle, STARTUP=16 -> gnt0 first high exactly 16 cycles after rst falls; busy high until then.
REQ-032 Add, LATENCY=2: cmd0 = opcode 010, A=3, B=5, cin=1, grant in cycle N, alsu_out=9 -> alsu_cmd = cmd0 from N+1; done=1, done_id=0, result=9 in cycle N+3.
REQ-033 Round-robin: req0 and req1 held high continuously -> grants alternate 0,1,0,1 and each done_id matches its grant.
REQ-034 Reject: cmd1 = opcode 111 granted in cycle N -> done=err=1, done_id=1 in N+1; alsu_cmd unchanged.
  - Also: cmd0 = opcode 010 with red_op_A=1 -> rejected the same way.
REQ-035 Reset mid-WAIT: valid grant, then rst one cycle later -> no done ever; all outputs 0; startup count restarts.
REQ-036 Hold-off: req1 asserted during WAIT of a req0 command -> gnt1 in the cycle req0's done is high.
